// File: rtl/simd_mem_loader_if.sv
// Host byte-stream port of simd_mem_loader: command bytes in, dump bytes out,
// both valid/ready handshaked on the rising edge.
interface simd_mem_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
    modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/simd_mem_loader.sv
// Loader/memory front-end for CPUtop: host preload, run-until-done, data dump.
// Optional RUN watchdog enabled by defining LOADER_TIMEOUT_EN.
module simd_mem_loader #(
    parameter int RST_HOLD   = 2,
    parameter int MAX_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    simd_mem_loader_if.slave    host,
    output logic                busy,
    output logic                err,
    output logic                cpu_rst,
    input  logic                done,
    input  logic [9:0]          instruction_address,
    output logic [17:0]         instruction_in,
    input  logic [9:0]          data_address,
    input  logic [15:0]         data_out,
    input  logic                data_R,
    input  logic                data_W,
    output logic [15:0]         data_in
);
    localparam int HW = $clog2(RST_HOLD + 2);

    typedef enum logic [3:0] {IDLE, ARGS, WRI, WRD, RUN, DRD, DHI, DLO, TERR} state_t;

    logic [17:0] imem [1024];
    logic [15:0] dmem [1024];

    state_t        state, state_next;
    logic [1:0]    cmd;
    logic [2:0]    argn;
    logic [33:0]   args;
    logic [10:0]   count, ptr;
    logic [HW-1:0] hold;
    logic [15:0]   rd_word;
    logic [15:0]   cnt_raw;
    logic          in_fire, out_fire, last_arg, run_timeout;

    assign in_fire  = host.in_valid && host.in_ready;
    assign out_fire = host.out_valid && host.out_ready;
    assign cnt_raw  = {args[7:0], host.in_data};
    assign last_arg = (cmd == 2'd1) ? (argn == 3'd4) :
                      (cmd == 2'd2) ? (argn == 3'd3) : (argn == 3'd1);

`ifdef LOADER_TIMEOUT_EN
    logic [15:0] wd;
    assign run_timeout = !cpu_rst && !done && (wd == 16'(MAX_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (rst || state != RUN) wd <= '0;
        else if (!cpu_rst)       wd <= wd + 16'd1;
    end
`else
    logic unused_cfg;
    assign run_timeout = 1'b0;
    assign unused_cfg  = (MAX_CYCLES != 0);
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_fire && host.in_data inside {8'h01, 8'h02, 8'h03}) state_next = ARGS;
            ARGS: if (in_fire && last_arg)
                      state_next = (cmd == 2'd1) ? WRI : (cmd == 2'd2) ? WRD : RUN;
            WRI, WRD: state_next = IDLE;
            RUN: begin
                if (!cpu_rst && done) state_next = (count == 11'd0) ? IDLE : DRD;
                else if (run_timeout) state_next = TERR;
            end
            DRD:  state_next = DHI;
            DHI:  if (out_fire) state_next = DLO;
            DLO:  if (out_fire) state_next = (ptr + 11'd1 == count) ? IDLE : DRD;
            TERR: if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign host.out_valid = state inside {DHI, DLO, TERR};

    always_comb begin
        host.out_data = 8'h00;
        case (state)
            DHI:     host.out_data = rd_word[15:8];
            DLO:     host.out_data = rd_word[7:0];
            TERR:    host.out_data = 8'hEE;
            default: host.out_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            host.in_ready <= 1'b0;
            err           <= 1'b0;
            cpu_rst       <= 1'b1;
            cmd           <= '0;
            argn          <= '0;
            args          <= '0;
            count         <= '0;
            ptr           <= '0;
            hold          <= '0;
            rd_word       <= '0;
        end else begin
            state         <= state_next;
            host.in_ready <= state_next inside {IDLE, ARGS};
            case (state)
                IDLE: if (in_fire) begin
                    cmd  <= host.in_data[1:0];
                    argn <= '0;
                    if (!(host.in_data inside {8'h01, 8'h02, 8'h03})) err <= 1'b1;
                end
                ARGS: if (in_fire) begin
                    args <= {args[25:0], host.in_data};
                    argn <= argn + 3'd1;
                    if (last_arg && cmd == 2'd3) begin
                        count <= (cnt_raw > 16'd1024) ? 11'd1024 : cnt_raw[10:0];
                        hold  <= '0;
                    end
                end
                RUN: begin
                    if (cpu_rst) begin
                        if (hold == HW'(RST_HOLD)) cpu_rst <= 1'b0;
                        else                       hold    <= hold + 1'b1;
                    end else if (done) begin
                        cpu_rst <= 1'b1;
                        ptr     <= '0;
                    end else if (run_timeout) begin
                        cpu_rst <= 1'b1;
                        err     <= 1'b1;
                    end
                end
                DRD: rd_word <= dmem[ptr[9:0]];
                DLO: if (out_fire) ptr <= ptr + 11'd1;
                default: ;
            endcase
        end
    end

    // All memory writes live on the falling edge; host writes land mid-cycle of
    // WRI/WRD, which never overlaps RUN, so CPU and host writes cannot collide.
    always_ff @(negedge clk) begin
        if (state == WRI) imem[args[33:24]] <= args[17:0];
        if (state == WRD)                          dmem[args[25:16]] <= args[15:0];
        else if (data_R && data_W && !cpu_rst)     dmem[data_address] <= data_out;
        if (rst) begin
            instruction_in <= '0;
            data_in        <= '0;
        end else begin
            instruction_in <= imem[instruction_address];
            if (data_R && !(data_W && !cpu_rst)) data_in <= dmem[data_address];
        end
    end
endmodule
